// File: rtl/fault_pkg.sv
// ---- fault_pkg: shared fault and sequencer types for fault_inject_seq (rev 1.0) ----
`default_nettype none

package fault_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    SA0  = 2'b01,
    SA1  = 2'b10,
    FLIP = 2'b11
  } fault_type_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WAIT   = 2'b01,
    INJECT = 2'b10
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fault_apply.sv
// ---- fault_apply: combinational single-bit corruption of a data word (rev 1.0) ----
`default_nettype none

module fault_apply
  import fault_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int LOC_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [LOC_W-1:0] loc,
  input  fault_type_t      ftype,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] mask;

  // An out-of-range loc matches no bit, so the mask is empty and data passes through.
  for (genvar i = 0; i < WIDTH; i++) begin : g_sel
    assign mask[i] = (loc == LOC_W'(i));
  end

  always_comb begin
    out = data;
    case (ftype)
      SA0:     out = data & ~mask;
      SA1:     out = data | mask;
      FLIP:    out = data ^ mask;
      default: out = data;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fault_inject_seq.sv
// ---- fault_inject_seq: delayed, timed single-bit fault injection on a registered stream (rev 1.0) ----
`default_nettype none

module fault_inject_seq
  import fault_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8,
  localparam int LOC_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [LOC_W-1:0] cfg_loc,
  input  logic [1:0]       cfg_type,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_dur,
  input  logic             abort,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  output logic             dout_valid,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             inj_active,
  output logic [15:0]      inj_count
);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [LOC_W-1:0] loc_q;
  fault_type_t      type_q;
  logic [CNT_W-1:0] dur_q;
  logic             load;
  logic [WIDTH-1:0] din_f;

  assign cfg_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign inj_active = (state == INJECT);
  assign load       = cfg_valid & cfg_ready;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (load && (cfg_type != 2'b00)) begin
          if (cfg_delay == '0) begin
            state_nx = INJECT;
            cnt_nx   = cfg_dur;
          end else begin
            state_nx = WAIT;
            cnt_nx   = cfg_delay;
          end
        end
      end
      WAIT: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (cnt == CNT_W'(1)) begin
          state_nx = INJECT;
          cnt_nx   = dur_q;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      INJECT: begin
        // A zero duration never counts down; only abort or reset leaves.
        if (abort) begin
          state_nx = IDLE;
        end else if (dur_q != '0) begin
          if (cnt == CNT_W'(1)) begin
            state_nx = IDLE;
          end else begin
            cnt_nx = cnt - CNT_W'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      loc_q     <= '0;
      type_q    <= NONE;
      dur_q     <= '0;
      inj_count <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (load) begin
        loc_q     <= cfg_loc;
        type_q    <= fault_type_t'(cfg_type);
        dur_q     <= cfg_dur;
        inj_count <= '0;
      end else if (inj_active && din_valid && (inj_count != 16'hFFFF)) begin
        inj_count <= inj_count + 16'd1;
      end
    end
  end

  fault_apply #(.WIDTH(WIDTH)) u_apply (
    .data  (din),
    .loc   (loc_q),
    .ftype (type_q),
    .out   (din_f)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      dout_valid <= 1'b0;
      dout       <= '0;
    end else begin
      dout_valid <= din_valid;
      if (din_valid) begin
        dout <= inj_active ? din_f : din;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/fault_inject_seq.md
FAULT_INJECT_SEQ -- requirements
Module: fault_inject_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data path width in bits (min 2).
REQ-002 The block SHALL have parameter CNT_W, default 8: width of the delay and duration counters.
REQ-003 The block SHALL derive local parameter LOC_W = $clog2(WIDTH).
REQ-004 The block SHALL have port clk, input, 1 bit: clock, all state updates on the rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have ports cfg_valid (input, 1) and cfg_ready (output, 1): fault-configuration handshake.
REQ-007 The block SHALL have port cfg_loc, input, LOC_W bits: target bit index.
REQ-008 The block SHALL have port cfg_type, input, 2 bits: 00 none, 01 stuck-at-0, 10 stuck-at-1, 11 bit-flip.
REQ-009 The block SHALL have ports cfg_delay and cfg_dur, input, CNT_W bits each: cycles before injection and cycles of injection; cfg_dur = 0 means permanent.
REQ-010 The block SHALL have port abort, input, 1 bit: cancel pending or active fault.
REQ-011 The block SHALL have ports din_valid (input, 1) and din (input, WIDTH): data stream in.
REQ-012 The block SHALL have ports dout_valid (output, 1) and dout (output, WIDTH): registered data stream out.
REQ-013 The block SHALL have status outputs busy (1), inj_active (1) and inj_count (16): injected-beat counter.

Function
REQ-014 The block SHALL implement FSM states IDLE, WAIT and INJECT; busy = (state != IDLE) and inj_active = (state == INJECT).
REQ-015 cfg_ready SHALL be 1 only in IDLE; a transfer occurs on an edge with cfg_valid & cfg_ready.
REQ-016 On transfer, the block SHALL latch loc/type/dur and clear inj_count to 0.
REQ-017 On transfer with type 00, the block SHALL stay in IDLE.
REQ-018 On transfer with delay 0, the block SHALL go to INJECT; otherwise it SHALL go to WAIT with the counter loaded with delay.
REQ-019 WAIT SHALL decrement the counter once per clock (not per data beat) and enter INJECT on the edge where the counter equals 1.
REQ-020 INJECT with dur > 0 SHALL last exactly dur cycles, then return to IDLE.
REQ-021 INJECT with dur = 0 SHALL remain in INJECT until abort.
REQ-022 abort in WAIT or INJECT SHALL force IDLE on the next edge, with priority over counter expiry.
REQ-023 abort in IDLE SHALL be ignored, including when a simultaneous transfer is accepted.
REQ-024 Datapath latency SHALL be 1 cycle: each edge loads dout_valid <= din_valid and dout <= apply(din) if inj_active in that cycle, else din.
REQ-025 apply() SHALL operate on bit loc only: SA0 clears it, SA1 sets it, flip inverts it; all other bits pass unchanged.
REQ-026 If loc >= WIDTH, apply() SHALL pass data unchanged, while the FSM sequences normally.
REQ-027 inj_count SHALL increment on each edge where inj_active & din_valid, saturating at 16'hFFFF.
REQ-028 When din_valid = 0, dout SHALL hold its previous value.

Reset
REQ-029 While reset = 0 at an edge, the block SHALL set state = IDLE, counters = 0, latched cfg = 0, dout = 0, dout_valid = 0 and inj_count = 0.
REQ-030 Outputs after reset SHALL be cfg_ready = 1, busy = 0 and inj_active = 0.
REQ-031 Reset asserted mid-WAIT or mid-INJECT SHALL discard the pending fault with no further injection.

Structure
REQ-032 Package fault_pkg SHALL hold fault_type_t (NONE, SA0, SA1, FLIP) and state_t (IDLE, WAIT, INJECT).
REQ-033 Combinational sub-module fault_apply (parameter WIDTH; ports data, loc, type, out) SHALL implement REQ-025/026 and be instantiated once.

Verification (WIDTH=8)
REQ-034 Reset low for 2 cycles -> dout=8'h00, dout_valid=0, cfg_ready=1, busy=0, inj_count=0.
REQ-035 cfg loc=3 type=SA1 delay=0 dur=2, continuous din=8'h00 -> dout 8'h08 for 2 beats then 8'h00, inj_count=2, busy falls after 2 cycles.
REQ-036 cfg loc=7 type=FLIP delay=3 dur=1, din=8'hFF -> 3 beats 8'hFF, 1 beat 8'h7F, then 8'hFF.
REQ-037 cfg loc=0 type=SA0 dur=0, din=8'h55 -> 8'h54 indefinitely; abort pulse in cycle c -> dout clean (8'h55) from the data of cycle c+1, cfg_ready=1.
REQ-038 cfg_valid held while busy -> no transfer and config unchanged; type=00 -> busy stays 0; din_valid gaps during INJECT -> inj_count counts only valid beats.
REQ-039 Reset low during INJECT with dur=0 -> IDLE, dout=8'h00 next cycle, no injection thereafter.
